mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-requester single-port memory arbiter: CPU and debug
// request/ack channels plus the memory-side strobe, address, data and status.
interface mem_arbiter_if;
   logic        c_req;
   logic        c_we;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic [31:0] c_rdata;
   logic        c_ack;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;

   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic        busy;
   logic        owner;

   // Requesters and memory model side
   modport master (
      output c_req, c_we, c_addr, c_wdata,
      output d_req, d_we, d_addr, d_wdata,
      output mem_rdata,
      input  c_rdata, c_ack, d_rdata, d_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy, owner
   );

   // Arbiter side
   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      input  d_req, d_we, d_addr, d_wdata,
      input  mem_rdata,
      output c_rdata, c_ack, d_rdata, d_ack,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy, owner
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting a CPU and a debug requester access to one
// single-port memory with a fixed read latency of MEM_LAT cycles.
module mem_arbiter #(
   parameter int unsigned MEM_LAT = 1
) (
   input logic         clk,
   input logic         reset,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

   localparam logic [2:0] WaitLoad = 3'(MEM_LAT - 1);

   state_e      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_grant_q, last_grant_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] c_rdata_q, c_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        grant;

   // On contention the requester that was not served last wins
   assign grant = (bus.c_req && bus.d_req) ? ~last_grant_q : bus.d_req;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      c_rdata_d    = c_rdata_q;
      d_rdata_d    = d_rdata_q;
      cnt_d        = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (bus.c_req || bus.d_req) begin
               owner_d = grant;
               we_d    = grant ? bus.d_we    : bus.c_we;
               addr_d  = grant ? bus.d_addr  : bus.c_addr;
               wdata_d = grant ? bus.d_wdata : bus.c_wdata;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (we_q) begin
               state_d = StAck;
            end else begin
               state_d = StWait;
               cnt_d   = WaitLoad;
            end
         end
         StWait: begin
            if (cnt_q == 3'd0) begin
               state_d = StAck;
               if (owner_q) begin
                  d_rdata_d = bus.mem_rdata;
               end else begin
                  c_rdata_d = bus.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         StAck: begin
            state_d      = StIdle;
            last_grant_d = owner_q;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         c_rdata_q    <= '0;
         d_rdata_q    <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         c_rdata_q    <= c_rdata_d;
         d_rdata_q    <= d_rdata_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.mem_en    = (state_q == StIssue);
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.c_ack     = (state_q == StAck) && !owner_q;
   assign bus.d_ack     = (state_q == StAck) && owner_q;
   assign bus.c_rdata   = c_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.busy      = (state_q != StIdle);
   assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=7,
// with a scoreboard queue of expected completions checked on each ack.
module tb_mem_arbiter;

   logic clk;
   logic reset;

   mem_arbiter_if bus1 ();
   mem_arbiter_if bus7 ();

   mem_arbiter #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
   mem_arbiter #(.MEM_LAT(7)) dut7 (.clk(clk), .reset(reset), .bus(bus7));

   typedef struct {
      logic        who;
      logic        rd;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Advance until dut1 acks, then pop and compare against the scoreboard head
   task automatic wait_ack(input int elapsed, input int budget, input bit drop);
      int   n;
      exp_t e;
      n = elapsed;
      while (!(bus1.c_ack || bus1.d_ack) && n < budget) begin
         tick();
         n++;
      end
      check("ack_seen", 32'(bus1.c_ack | bus1.d_ack), 32'd1);
      check("ack_overlap", 32'(bus1.c_ack & bus1.d_ack), 32'd0);
      if (!(bus1.c_ack || bus1.d_ack)) return;
      if (sb.size() == 0) begin
         check("sb_nonempty", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      check("ack_who", 32'(bus1.d_ack), 32'(e.who));
      check("ack_lat", n, e.lat);
      if (e.rd) check("rdata", e.who ? bus1.d_rdata : bus1.c_rdata, e.rdata);
      if (drop) begin
         if (e.who) bus1.d_req = 1'b0;
         else bus1.c_req = 1'b0;
      end
   endtask

   initial begin
      int pulses;
      int ack_cyc;
      int en_cnt;

      bus1.c_req = 0; bus1.c_we = 0; bus1.c_addr = 0; bus1.c_wdata = 0;
      bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = 0; bus1.d_wdata = 0;
      bus1.mem_rdata = 0;
      bus7.c_req = 0; bus7.c_we = 0; bus7.c_addr = 0; bus7.c_wdata = 0;
      bus7.d_req = 0; bus7.d_we = 0; bus7.d_addr = 0; bus7.d_wdata = 0;
      bus7.mem_rdata = 0;
      reset = 1'b1;
      tick();
      do_reset();

      // Reset state
      check("rst_busy", 32'(bus1.busy), 32'd0);
      check("rst_owner", 32'(bus1.owner), 32'd0);
      check("rst_mem_en", 32'(bus1.mem_en), 32'd0);
      check("rst_mem_we", 32'(bus1.mem_we), 32'd0);
      check("rst_acks", 32'({bus1.c_ack, bus1.d_ack}), 32'd0);
      check("rst_c_rdata", bus1.c_rdata, 32'd0);
      check("rst_d_rdata", bus1.d_rdata, 32'd0);
      check("rst_mem_addr", bus1.mem_addr, 32'd0);

      // CPU read, MEM_LAT=1
      bus1.c_req = 1; bus1.c_we = 0; bus1.c_addr = 32'h10;
      sb.push_back('{who: 1'b0, rd: 1'b1, rdata: 32'hDEADBEEF, lat: 3});
      tick();
      check("rd_issue_en", 32'(bus1.mem_en), 32'd1);
      check("rd_issue_we", 32'(bus1.mem_we), 32'd0);
      check("rd_issue_addr", bus1.mem_addr, 32'h10);
      check("rd_issue_busy", 32'(bus1.busy), 32'd1);
      tick();
      check("rd_wait_en", 32'(bus1.mem_en), 32'd0);
      bus1.mem_rdata = 32'hDEADBEEF;
      wait_ack(2, 12, 1'b1);
      check("rd_other_rdata", bus1.d_rdata, 32'd0);
      bus1.mem_rdata = 32'h0;
      tick();
      check("rd_idle_busy", 32'(bus1.busy), 32'd0);
      check("rd_single_ack", 32'(bus1.c_ack), 32'd0);

      // Debug write: no read capture
      bus1.d_req = 1; bus1.d_we = 1; bus1.d_addr = 32'h20; bus1.d_wdata = 32'h12345678;
      sb.push_back('{who: 1'b1, rd: 1'b0, rdata: 32'h0, lat: 2});
      tick();
      check("wr_issue_en", 32'(bus1.mem_en), 32'd1);
      check("wr_issue_we", 32'(bus1.mem_we), 32'd1);
      check("wr_issue_addr", bus1.mem_addr, 32'h20);
      check("wr_issue_wdata", bus1.mem_wdata, 32'h12345678);
      check("wr_issue_owner", 32'(bus1.owner), 32'd1);
      bus1.mem_rdata = 32'hBAD0BAD0;
      wait_ack(1, 12, 1'b1);
      check("wr_c_rdata_hold", bus1.c_rdata, 32'hDEADBEEF);
      check("wr_d_rdata_hold", bus1.d_rdata, 32'd0);
      tick();
      check("wr_hold_addr", bus1.mem_addr, 32'h20);

      // Both requesting continuously from reset: CPU, debug, CPU, debug
      do_reset();
      bus1.c_req = 1; bus1.c_we = 1; bus1.c_addr = 32'h100; bus1.c_wdata = 32'hC0C0;
      bus1.d_req = 1; bus1.d_we = 1; bus1.d_addr = 32'h200; bus1.d_wdata = 32'hD0D0;
      for (int i = 0; i < 4; i++) sb.push_back('{who: i[0], rd: 1'b0, rdata: 32'h0, lat: 2});
      for (int i = 0; i < 4; i++) begin
         wait_ack(0, 8, 1'b0);
         tick();
      end
      bus1.c_req = 0; bus1.d_req = 0;
      tick();
      check("rr_drained", 32'(sb.size()), 32'd0);

      // Debug read to load d_rdata, then a debug read aborted by reset in WAIT
      bus1.mem_rdata = 32'h5555AAAA;
      bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 32'h30;
      sb.push_back('{who: 1'b1, rd: 1'b1, rdata: 32'h5555AAAA, lat: 3});
      wait_ack(0, 12, 1'b1);
      tick();
      bus1.d_req = 1;
      tick();
      tick();
      check("abort_busy_wait", 32'(bus1.busy), 32'd1);
      reset = 1'b1; bus1.d_req = 0; bus1.mem_rdata = 32'h77777777;
      tick();
      reset = 1'b0;
      check("abort_busy", 32'(bus1.busy), 32'd0);
      check("abort_d_ack", 32'(bus1.d_ack), 32'd0);
      check("abort_d_rdata", bus1.d_rdata, 32'd0);
      check("abort_owner", 32'(bus1.owner), 32'd0);
      check("abort_mem_addr", bus1.mem_addr, 32'd0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus1.d_ack) pulses++;
      end
      check("abort_no_ack", pulses, 0);
      bus1.mem_rdata = 32'h0BADF00D;
      bus1.c_req = 1; bus1.c_we = 0; bus1.c_addr = 32'h44;
      sb.push_back('{who: 1'b0, rd: 1'b1, rdata: 32'h0BADF00D, lat: 3});
      wait_ack(0, 12, 1'b1);
      tick();
      check("post_abort_busy", 32'(bus1.busy), 32'd0);

      // CPU drops c_req during WAIT
      bus1.mem_rdata = 32'h13579BDF;
      bus1.c_req = 1; bus1.c_we = 0; bus1.c_addr = 32'h50;
      sb.push_back('{who: 1'b0, rd: 1'b1, rdata: 32'h13579BDF, lat: 3});
      tick();
      tick();
      bus1.c_req = 0;
      wait_ack(2, 12, 1'b0);
      tick();
      check("drop_busy", 32'(bus1.busy), 32'd0);
      check("drop_ack_once", 32'(bus1.c_ack), 32'd0);
      tick();
      check("drop_no_restart", 32'(bus1.busy), 32'd0);

      // MEM_LAT=7 CPU read: mem_rdata changes every cycle
      ack_cyc = -1;
      en_cnt = 0;
      bus7.c_req = 1; bus7.c_we = 0; bus7.c_addr = 32'h40;
      for (int n = 1; n <= 12 && ack_cyc < 0; n++) begin
         tick();
         bus7.mem_rdata = 32'hA0000000 | 32'(n);
         if (bus7.mem_en) en_cnt++;
         if (bus7.c_ack) begin
            ack_cyc = n;
            bus7.c_req = 0;
         end
      end
      check("lat7_ack_cycle", ack_cyc, 9);
      check("lat7_mem_en_cnt", en_cnt, 1);
      check("lat7_c_rdata", bus7.c_rdata, 32'hA0000008);
      tick();
      check("lat7_idle", 32'(bus7.busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
